// File: rtl/fb_scanout_if.sv
// Scan-out bundle: VGA timing in, frame-RAM read port, bank-swap handshake, pixel stream out.
// The slave side is the scan-out engine; the master side is its environment.
interface fb_scanout_if #(
  parameter int DW = 8,
  parameter int AW = 17
);
  logic          pixel_ce;
  logic [9:0]    DrawX;
  logic [9:0]    DrawY;
  logic          hs_in;
  logic          vs_in;
  logic          blank_in;
  logic          swap_req;
  logic          swap_ack;
  logic          front_bank;
  logic          rd_en;
  logic [AW:0]   rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] color_out;
  logic          hs_out;
  logic          vs_out;
  logic          blank_out;
  logic [7:0]    frame_cnt;

  modport slave (
    input  pixel_ce, DrawX, DrawY, hs_in, vs_in, blank_in, swap_req, rd_data,
    output swap_ack, front_bank, rd_en, rd_addr, color_out, hs_out, vs_out, blank_out, frame_cnt
  );

  modport master (
    output pixel_ce, DrawX, DrawY, hs_in, vs_in, blank_in, swap_req, rd_data,
    input  swap_ack, front_bank, rd_en, rd_addr, color_out, hs_out, vs_out, blank_out, frame_cnt
  );
endinterface

// File: rtl/fb_scanout.sv
// 2x-upscaling read engine for a double-buffered indexed frame RAM; output lags DrawX/DrawY by
// 2 pixel_ce strobes. No backpressure: the RAM must answer one Clk after rd_en.
module fb_scanout #(
  parameter int            W            = 320,
  parameter int            H            = 240,
  parameter int            DW           = 8,
  parameter int            AW           = 17,
  parameter logic [DW-1:0] BORDER_COLOR = 8'h00
) (
  input  logic         Clk,
  input  logic         Reset,
  fb_scanout_if.slave  bus
);

  localparam logic [9:0]    X_END = 10'(2 * W);
  localparam logic [9:0]    Y_END = 10'(2 * H);
  localparam logic [AW-1:0] W_A   = AW'(W);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_ACK} swap_state_t;

  swap_state_t   state, state_nxt;
  logic          flip;
  logic          active;
  logic          vbs;
  logic [AW-1:0] line_base;
  logic [AW-1:0] base_nxt;
  logic [AW-1:0] offset;
  logic          act_d;
  logic          ce_d;
  logic [DW-1:0] pix_q;
  logic          hs_d1, vs_d1, blank_d1;

  assign active = (bus.DrawX < X_END) && (bus.DrawY < Y_END) && bus.blank_in;
  assign vbs    = bus.pixel_ce && (bus.DrawX == 10'd0) && (bus.DrawY == Y_END);

  // Each source line is scanned on two display lines, so the base only advances on even ones.
  always_comb begin
    base_nxt = line_base;
    if (bus.DrawX == 10'd0) begin
      if (bus.DrawY == 10'd0)
        base_nxt = '0;
      else if (!bus.DrawY[0])
        base_nxt = line_base + W_A;
    end
  end

  assign offset = base_nxt + AW'(bus.DrawX[9:1]);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      line_base     <= '0;
      bus.rd_en     <= 1'b0;
      bus.rd_addr   <= '0;
      act_d         <= 1'b0;
      ce_d          <= 1'b0;
      pix_q         <= BORDER_COLOR;
      hs_d1         <= 1'b1;
      vs_d1         <= 1'b1;
      blank_d1      <= 1'b0;
      bus.color_out <= BORDER_COLOR;
      bus.hs_out    <= 1'b1;
      bus.vs_out    <= 1'b1;
      bus.blank_out <= 1'b0;
      bus.frame_cnt <= 8'd0;
    end else begin
      ce_d      <= bus.pixel_ce;
      bus.rd_en <= 1'b0;
      // RAM data is only valid in the Clk following the read strobe.
      if (ce_d)
        pix_q <= act_d ? bus.rd_data : BORDER_COLOR;
      if (bus.pixel_ce) begin
        line_base     <= base_nxt;
        bus.rd_addr   <= {bus.front_bank, offset};
        bus.rd_en     <= active;
        act_d         <= active;
        hs_d1         <= bus.hs_in;
        vs_d1         <= bus.vs_in;
        blank_d1      <= bus.blank_in;
        bus.color_out <= pix_q;
        bus.hs_out    <= hs_d1;
        bus.vs_out    <= vs_d1;
        bus.blank_out <= blank_d1;
        if (vbs)
          bus.frame_cnt <= bus.frame_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state          <= S_IDLE;
      bus.front_bank <= 1'b0;
      bus.swap_ack   <= 1'b0;
    end else begin
      state        <= state_nxt;
      bus.swap_ack <= (state == S_ACK);
      if (flip)
        bus.front_bank <= ~bus.front_bank;
    end
  end

  // Flip only out of PEND, so a request first seen on a VBS waits for the next one.
  always_comb begin
    state_nxt = state;
    flip      = 1'b0;
    case (state)
      S_IDLE: if (bus.swap_req) state_nxt = S_PEND;
      S_PEND: begin
        if (!bus.swap_req) begin
          state_nxt = S_IDLE;
        end else if (vbs) begin
          flip      = 1'b1;
          state_nxt = S_ACK;
        end
      end
      S_ACK:   if (!bus.swap_req) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: RAM model plus a scoreboard of expected pixels, and per-scenario checks.
module tb_fb_scanout;
  localparam int         W      = 320;
  localparam int         H      = 240;
  localparam logic [7:0] BORDER = 8'h00;

  typedef struct {
    logic [7:0]  color;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        act;
    logic [17:0] addr;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;
  fb_scanout_if #(.DW(8), .AW(17)) bus();

  fb_scanout #(.W(W), .H(H), .DW(8), .AW(17), .BORDER_COLOR(BORDER)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus));

  always #10 Clk = ~Clk;

  // Bank 0 holds offset&FF, bank 1 its complement, so a wrong bank shows up in the colour.
  function automatic logic [7:0] ram_val(input logic [17:0] a);
    return a[17] ? ~a[7:0] : a[7:0];
  endfunction

  assign bus.rd_data = bus.rd_en ? ram_val(bus.rd_addr) : 8'hEE;

  exp_t       sb[$];
  exp_t       mon_e;
  int         vectors = 0;
  int         miscompares = 0;
  bit         mon_en = 0;
  logic       exp_bank = 1'b0;
  logic [7:0] exp_frames = 8'd0;

  function automatic exp_t reset_item();
    exp_t e;
    e.color = BORDER; e.hs = 1'b1; e.vs = 1'b1; e.blank = 1'b0; e.act = 1'b0; e.addr = '0;
    return e;
  endfunction

  // Scoreboard: the entry pushed on one strobe is due at the DUT outputs on the next.
  always @(posedge Clk) begin
    if (mon_en && !Reset) begin
      if (bus.pixel_ce && sb.size() > 0) begin
        #1;
        vectors++;
        if (bus.rd_en !== sb[$].act) begin miscompares++; $display("FAIL rd_en_strobe: got %b want %b", bus.rd_en, sb[$].act); end
        if (sb[$].act) begin
          vectors++;
          if (bus.rd_addr !== sb[$].addr) begin miscompares++; $display("FAIL rd_addr: got %h want %h", bus.rd_addr, sb[$].addr); end
        end
        if (sb.size() >= 2) begin
          mon_e = sb.pop_front();
          vectors++;
          if (bus.color_out !== mon_e.color) begin miscompares++; $display("FAIL color_out: got %h want %h", bus.color_out, mon_e.color); end
          vectors++;
          if ({bus.hs_out, bus.vs_out, bus.blank_out} !== {mon_e.hs, mon_e.vs, mon_e.blank}) begin
            miscompares++;
            $display("FAIL sync_align: got hs/vs/blank %b%b%b want %b%b%b", bus.hs_out, bus.vs_out, bus.blank_out, mon_e.hs, mon_e.vs, mon_e.blank);
          end
        end
      end else if (!bus.pixel_ce) begin
        #1;
        vectors++;
        if (bus.rd_en !== 1'b0) begin miscompares++; $display("FAIL rd_en_width: got %b want 0", bus.rd_en); end
      end
    end
  end

  // One pixel_ce period; req >= 0 changes swap_req on the same edge as the pixel inputs.
  task automatic step(input int x, input int y, input bit kill_blank = 1'b0, input int req = -1);
    exp_t e;
    @(negedge Clk);
    bus.DrawX    = 10'(x);
    bus.DrawY    = 10'(y);
    bus.hs_in    = !(x >= 656 && x < 752);
    bus.vs_in    = !(y >= 490 && y < 492);
    bus.blank_in = (x < 640 && y < 480) && !kill_blank;
    if (req >= 0) bus.swap_req = req[0];
    bus.pixel_ce = 1'b1;
    e.act   = (x < 2 * W) && (y < 2 * H) && !kill_blank;
    e.addr  = {exp_bank, 17'((y / 2) * W + x / 2)};
    e.color = e.act ? ram_val(e.addr) : BORDER;
    e.hs    = bus.hs_in;
    e.vs    = bus.vs_in;
    e.blank = bus.blank_in;
    sb.push_back(e);
    if (x == 0 && y == 2 * H) exp_frames = exp_frames + 8'd1;
    @(negedge Clk);
    bus.pixel_ce = 1'b0;
  endtask

  task automatic run_lines(input int y0, input int y1);
    for (int y = y0; y <= y1; y++) begin
      step(0, y);
      step(1 + (y * 7) % 699, y);
    end
  endtask

  task automatic test_reset();
    bus.pixel_ce = 0; bus.DrawX = 0; bus.DrawY = 0; bus.hs_in = 1; bus.vs_in = 1;
    bus.blank_in = 0; bus.swap_req = 0;
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    vectors++; if (bus.rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en: got %b want 0", bus.rd_en); end
    vectors++; if (bus.rd_addr !== 18'd0) begin miscompares++; $display("FAIL reset_rd_addr: got %h want 0", bus.rd_addr); end
    vectors++; if (bus.color_out !== BORDER) begin miscompares++; $display("FAIL reset_color: got %h want %h", bus.color_out, BORDER); end
    vectors++; if ({bus.hs_out, bus.vs_out, bus.blank_out} !== 3'b110) begin miscompares++; $display("FAIL reset_sync: got %b%b%b want 110", bus.hs_out, bus.vs_out, bus.blank_out); end
    vectors++; if (bus.front_bank !== 1'b0) begin miscompares++; $display("FAIL reset_bank: got %b want 0", bus.front_bank); end
    vectors++; if (bus.swap_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b want 0", bus.swap_ack); end
    vectors++; if (bus.frame_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_frame_cnt: got %0d want 0", bus.frame_cnt); end
    @(negedge Clk);
    sb.delete();
    sb.push_back(reset_item());
    exp_bank = 1'b0; exp_frames = 8'd0;
    Reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_pixel_map();
    run_lines(0, 6);
    step(0, 7);
    step(5, 7);
    vectors++; if (bus.rd_en !== 1'b1 || bus.rd_addr !== 18'd962) begin miscompares++; $display("FAIL map_addr: got en=%b addr=%0d want en=1 addr=962", bus.rd_en, bus.rd_addr); end
    step(6, 7);
    vectors++; if (bus.color_out !== 8'hC2) begin miscompares++; $display("FAIL map_color: got %h want c2", bus.color_out); end
    step(8, 7, 1'b1);
    step(9, 7);
    vectors++; if (bus.color_out !== BORDER) begin miscompares++; $display("FAIL blank_gate: got %h want %h", bus.color_out, BORDER); end
  endtask

  task automatic test_last_pixel();
    run_lines(8, 478);
    step(0, 479);
    step(638, 479);
    vectors++; if (bus.rd_addr !== 18'h12BFF) begin miscompares++; $display("FAIL last_addr_638: got %h want 12bff", bus.rd_addr); end
    step(639, 479);
    vectors++; if (bus.rd_addr !== 18'h12BFF) begin miscompares++; $display("FAIL last_addr_639: got %h want 12bff", bus.rd_addr); end
    vectors++; if (bus.color_out !== 8'hFF) begin miscompares++; $display("FAIL last_color_638: got %h want ff", bus.color_out); end
    step(640, 479);
    vectors++; if (bus.rd_en !== 1'b0) begin miscompares++; $display("FAIL right_edge_rd_en: got %b want 0", bus.rd_en); end
    vectors++; if (bus.color_out !== 8'hFF) begin miscompares++; $display("FAIL last_color_639: got %h want ff", bus.color_out); end
    step(641, 479);
    vectors++; if (bus.color_out !== BORDER) begin miscompares++; $display("FAIL right_edge_color: got %h want %h", bus.color_out, BORDER); end
    step(0, 480);
    vectors++; if (bus.frame_cnt !== exp_frames) begin miscompares++; $display("FAIL frame_cnt_vbs: got %0d want %0d", bus.frame_cnt, exp_frames); end
  endtask

  task automatic test_swap();
    run_lines(0, 99);
    step(0, 100, 1'b0, 1);
    run_lines(101, 102);
    vectors++; if (bus.front_bank !== 1'b0 || bus.swap_ack !== 1'b0) begin miscompares++; $display("FAIL swap_pend: got bank=%b ack=%b want 0/0", bus.front_bank, bus.swap_ack); end
    run_lines(103, 479);
    step(0, 480);
    vectors++; if (bus.front_bank !== 1'b1) begin miscompares++; $display("FAIL swap_flip: got %b want 1", bus.front_bank); end
    vectors++; if (bus.swap_ack !== 1'b0) begin miscompares++; $display("FAIL swap_ack_early: got %b want 0", bus.swap_ack); end
    exp_bank = 1'b1;
    @(posedge Clk); #1;
    vectors++; if (bus.swap_ack !== 1'b1) begin miscompares++; $display("FAIL swap_ack_rise: got %b want 1", bus.swap_ack); end
    @(negedge Clk); bus.swap_req = 1'b0;
    @(posedge Clk); #1;
    vectors++; if (bus.swap_ack !== 1'b1) begin miscompares++; $display("FAIL swap_ack_hold: got %b want 1", bus.swap_ack); end
    @(posedge Clk); #1;
    vectors++; if (bus.swap_ack !== 1'b0) begin miscompares++; $display("FAIL swap_ack_fall: got %b want 0", bus.swap_ack); end
    run_lines(0, 3);
    step(0, 4);
    step(10, 4);
    vectors++; if (bus.rd_addr !== {1'b1, 17'd645}) begin miscompares++; $display("FAIL new_bank_addr: got %h want %h", bus.rd_addr, {1'b1, 17'd645}); end
  endtask

  task automatic test_swap_on_vbs();
    step(0, 480, 1'b0, 1);
    vectors++; if (bus.front_bank !== 1'b1) begin miscompares++; $display("FAIL vbs_req_noflip: got %b want 1", bus.front_bank); end
    repeat (3) @(posedge Clk);
    #1;
    vectors++; if (bus.swap_ack !== 1'b0) begin miscompares++; $display("FAIL vbs_req_ack: got %b want 0", bus.swap_ack); end
    step(0, 480);
    vectors++; if (bus.front_bank !== 1'b0) begin miscompares++; $display("FAIL vbs_req_late_flip: got %b want 0", bus.front_bank); end
    exp_bank = 1'b0;
    @(posedge Clk); #1;
    vectors++; if (bus.swap_ack !== 1'b1) begin miscompares++; $display("FAIL vbs_req_ack_rise: got %b want 1", bus.swap_ack); end
    @(negedge Clk); bus.swap_req = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    vectors++; if (bus.swap_ack !== 1'b0) begin miscompares++; $display("FAIL vbs_req_ack_fall: got %b want 0", bus.swap_ack); end
  endtask

  task automatic test_abort();
    @(negedge Clk); bus.swap_req = 1'b1;
    repeat (3) @(negedge Clk);
    bus.swap_req = 1'b0;
    repeat (2) @(negedge Clk);
    step(0, 480);
    vectors++; if (bus.front_bank !== 1'b0) begin miscompares++; $display("FAIL abort_noflip: got %b want 0", bus.front_bank); end
    repeat (3) @(posedge Clk);
    #1;
    vectors++; if (bus.swap_ack !== 1'b0) begin miscompares++; $display("FAIL abort_ack: got %b want 0", bus.swap_ack); end
  endtask

  task automatic test_wrap();
    while (exp_frames != 8'd255) step(0, 480);
    vectors++; if (bus.frame_cnt !== 8'd255) begin miscompares++; $display("FAIL frame_cnt_255: got %0d want 255", bus.frame_cnt); end
    step(660, 480);
    step(0, 490);
    step(0, 480);
    vectors++; if (bus.frame_cnt !== 8'd0) begin miscompares++; $display("FAIL frame_cnt_wrap: got %0d want 0", bus.frame_cnt); end
    step(700, 491);
    step(0, 0);
    step(1, 0);
  endtask

  task automatic test_reset_midline();
    step(0, 480, 1'b0, 1);
    step(0, 480);
    exp_bank = 1'b1;
    @(negedge Clk); bus.swap_req = 1'b0;
    while (exp_frames != 8'd255) step(0, 480);
    step(0, 0);
    step(300, 0);
    vectors++; if (bus.front_bank !== 1'b1 || bus.frame_cnt !== 8'd255 || bus.rd_en !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset_state: got bank=%b cnt=%0d en=%b want 1/255/1", bus.front_bank, bus.frame_cnt, bus.rd_en);
    end
    #3 Reset = 1'b1;
    #1;
    vectors++; if (bus.rd_en !== 1'b0 || bus.rd_addr !== 18'd0) begin miscompares++; $display("FAIL midreset_rd: got en=%b addr=%h want 0/0", bus.rd_en, bus.rd_addr); end
    vectors++; if (bus.color_out !== BORDER) begin miscompares++; $display("FAIL midreset_color: got %h want %h", bus.color_out, BORDER); end
    vectors++; if ({bus.hs_out, bus.vs_out, bus.blank_out} !== 3'b110) begin miscompares++; $display("FAIL midreset_sync: got %b%b%b want 110", bus.hs_out, bus.vs_out, bus.blank_out); end
    vectors++; if (bus.front_bank !== 1'b0 || bus.swap_ack !== 1'b0) begin miscompares++; $display("FAIL midreset_swap: got bank=%b ack=%b want 0/0", bus.front_bank, bus.swap_ack); end
    vectors++; if (bus.frame_cnt !== 8'd0) begin miscompares++; $display("FAIL midreset_frame_cnt: got %0d want 0", bus.frame_cnt); end
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    sb.delete();
    sb.push_back(reset_item());
    exp_bank = 1'b0; exp_frames = 8'd0;
    Reset = 1'b0;
    run_lines(0, 3);
    step(0, 4);
    vectors++; if (bus.rd_addr !== {1'b0, 17'd640}) begin miscompares++; $display("FAIL post_reset_addr: got %h want %h", bus.rd_addr, {1'b0, 17'd640}); end
    step(2, 4);
  endtask

  initial begin
    test_reset();
    test_pixel_map();
    test_last_pixel();
    test_swap();
    test_swap_on_vbs();
    test_abort();
    test_wrap();
    test_reset_midline();
    repeat (2) @(negedge Clk);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
